// File: rtl/i2c_ctrl_pkg.sv
// Shared scheduler definitions: state encoding, status encoding, default widths.
// No logic of its own; imported by the scheduler, its arbiter and the bus interface.
// Also used by the i2c master bench, so keep encodings stable.
package i2c_ctrl_pkg;

  // Scheduler FSM states (plain constants so older tools and benches can decode them)
  typedef logic [2:0] sched_state_t;
  localparam sched_state_t S_IDLE  = 3'd0;
  localparam sched_state_t S_START = 3'd1;
  localparam sched_state_t S_ADDR  = 3'd2;
  localparam sched_state_t S_AACK  = 3'd3;
  localparam sched_state_t S_DATA  = 3'd4;
  localparam sched_state_t S_DACK  = 3'd5;
  localparam sched_state_t S_STOP  = 3'd6;

  // Transaction completion status
  localparam logic ST_OK  = 1'b0;
  localparam logic ST_ERR = 1'b1;

  // Default configuration
  localparam int DEF_NREQ   = 4;
  localparam int DEF_LENW   = 4;
  localparam int DEF_ACK_TO = 16;
  localparam int DEF_GAP    = 2;

  // Index width for n requesters, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_txn_sched_if.sv
// Bundle between the transaction scheduler, its requesters and the i2c bit-level master.
// master modport: scheduler view (drives grant/pulses and master controls).
// slave modport: environment view (drives requests, tx bytes and master acks).
interface i2c_txn_sched_if
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LENW = DEF_LENW
);
  // requester side
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*8-1:0]    req_addr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*8-1:0]    tx_byte;
  logic [NREQ-1:0]      tx_pop;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  // bit-level master side
  logic                 m_start;
  logic                 m_aout;
  logic                 m_validaddr;
  logic                 m_dout;
  logic                 m_validdata;
  logic                 m_slave_ack;
  logic                 m_data_ack;

  modport master (
    input  req_valid, req_addr, req_len, tx_byte, m_slave_ack, m_data_ack,
    output tx_pop, grant, done, err,
    output m_start, m_aout, m_validaddr, m_dout, m_validdata
  );

  modport slave (
    output req_valid, req_addr, req_len, tx_byte, m_slave_ack, m_data_ack,
    input  tx_pop, grant, done, err,
    input  m_start, m_aout, m_validaddr, m_dout, m_validdata
  );

endinterface

// File: rtl/i2c_txn_sched_rr_arbiter.sv
// Round-robin arbiter: first set bit of req searching upward from ptr with wrap.
// Purely combinational, zero latency; no backpressure (caller decides when to take gnt).
// Ports: req (requests), ptr (search start) -> gnt (one-hot, 0 if none), idx (winner index).
module rr_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// Shares one i2c bit-level master between NREQ requesters: round-robin grant, then
// start / serial address / ack / serial data bytes with per-byte ack / stop; done or err pulse.
// Latency: START 1 cycle after request seen; requester bytes are consumed via tx_pop pulses.
// Ports: clk, reset (async active-high), bus (master modport of i2c_txn_sched_if).
module i2c_txn_sched
  import i2c_ctrl_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int LENW   = DEF_LENW,
  parameter int ACK_TO = DEF_ACK_TO,
  parameter int GAP    = DEF_GAP
) (
  input logic               clk,
  input logic               reset,
  i2c_txn_sched_if.master   bus
);

  localparam int IW  = idx_w(NREQ);
  localparam int TOW = $clog2(ACK_TO + 1);
  localparam int GW  = $clog2(GAP + 1);

  // state registers
  sched_state_t    state_q, state_n;
  logic [2:0]      bitcnt_q, bitcnt_n;
  logic [TOW-1:0]  tocnt_q, tocnt_n;
  logic [GW-1:0]   gapcnt_q, gapcnt_n;
  logic [LENW-1:0] len_q, len_n;
  logic [7:0]      addr_q, addr_n;
  logic [7:0]      shreg_q, shreg_n;
  logic [IW-1:0]   g_q, g_n;
  logic [IW-1:0]   rr_q, rr_n;
  logic            status_q, status_n;

  // next values of the registered outputs
  logic [NREQ-1:0] grant_n, pop_n, done_n, err_n;
  logic            start_n, aout_n, va_n, dout_n, vd_n;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            ack;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // AACK and DACK share one handler; only the ack source differs
  assign ack = (state_q == S_AACK) ? bus.m_slave_ack : bus.m_data_ack;

  always_comb begin
    state_n  = state_q;
    bitcnt_n = bitcnt_q;
    tocnt_n  = tocnt_q;
    gapcnt_n = gapcnt_q;
    len_n    = len_q;
    addr_n   = addr_q;
    shreg_n  = shreg_q;
    g_n      = g_q;
    rr_n     = rr_q;
    status_n = status_q;
    pop_n    = '0;
    done_n   = '0;
    err_n    = '0;
    grant_n  = '0;

    case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          g_n     = arb_idx;
          addr_n  = bus.req_addr[arb_idx*8 +: 8];
          len_n   = bus.req_len[arb_idx*LENW +: LENW];
          rr_n    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        bitcnt_n = 3'd7;
        state_n  = S_ADDR;
      end
      S_ADDR: begin
        if (bitcnt_q == 3'd0) begin
          tocnt_n = '0;
          state_n = S_AACK;
        end else begin
          bitcnt_n = bitcnt_q - 1'b1;
        end
      end
      S_AACK, S_DACK: begin
        // ack is tested before the timeout so a late ack on the final cycle still wins
        if (ack) begin
          if (len_q == '0) begin
            status_n = ST_OK;
            gapcnt_n = '0;
            state_n  = S_STOP;
          end else begin
            shreg_n    = bus.tx_byte[g_q*8 +: 8];
            pop_n[g_q] = 1'b1;
            bitcnt_n   = 3'd7;
            state_n    = S_DATA;
          end
        end else if (tocnt_q == TOW'(ACK_TO - 1)) begin
          status_n = ST_ERR;
          gapcnt_n = '0;
          state_n  = S_STOP;
        end else begin
          tocnt_n = tocnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bitcnt_q == 3'd0) begin
          len_n   = len_q - 1'b1;
          tocnt_n = '0;
          state_n = S_DACK;
        end else begin
          bitcnt_n = bitcnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (gapcnt_q == GW'(GAP - 1)) begin
          state_n = S_IDLE;
        end else begin
          gapcnt_n = gapcnt_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe (bit index = bitcnt of that cycle).
    if (state_n != S_IDLE) begin
      grant_n[g_n] = 1'b1;
    end
    if (state_n == S_STOP && gapcnt_n == GW'(GAP - 1)) begin
      if (status_n == ST_ERR) begin
        err_n[g_n] = 1'b1;
      end else begin
        done_n[g_n] = 1'b1;
      end
    end
    start_n = (state_n != S_IDLE) && (state_n != S_STOP);
    va_n    = (state_n == S_ADDR);
    aout_n  = va_n & addr_n[bitcnt_n];
    vd_n    = (state_n == S_DATA);
    dout_n  = vd_n & shreg_n[bitcnt_n];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      bitcnt_q        <= '0;
      tocnt_q         <= '0;
      gapcnt_q        <= '0;
      len_q           <= '0;
      addr_q          <= '0;
      shreg_q         <= '0;
      g_q             <= '0;
      rr_q            <= '0;
      status_q        <= ST_OK;
      bus.grant       <= '0;
      bus.tx_pop      <= '0;
      bus.done        <= '0;
      bus.err         <= '0;
      bus.m_start     <= 1'b0;
      bus.m_aout      <= 1'b0;
      bus.m_validaddr <= 1'b0;
      bus.m_dout      <= 1'b0;
      bus.m_validdata <= 1'b0;
    end else begin
      state_q         <= state_n;
      bitcnt_q        <= bitcnt_n;
      tocnt_q         <= tocnt_n;
      gapcnt_q        <= gapcnt_n;
      len_q           <= len_n;
      addr_q          <= addr_n;
      shreg_q         <= shreg_n;
      g_q             <= g_n;
      rr_q            <= rr_n;
      status_q        <= status_n;
      bus.grant       <= grant_n;
      bus.tx_pop      <= pop_n;
      bus.done        <= done_n;
      bus.err         <= err_n;
      bus.m_start     <= start_n;
      bus.m_aout      <= aout_n;
      bus.m_validaddr <= va_n;
      bus.m_dout      <= dout_n;
      bus.m_validdata <= vd_n;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Testbench for i2c_txn_sched: directed transactions, scoreboard of expected bus events.
// A requester/ack-responder model drives inputs; a monitor pops and compares events.
// Ports: none (top-level bench).
module tb_i2c_txn_sched;
  import i2c_ctrl_pkg::*;

  localparam int NREQ   = 4;
  localparam int LENW   = 4;
  localparam int ACK_TO = 16;
  localparam int GAP    = 2;

  localparam logic [2:0] EV_GRANT = 3'd0;
  localparam logic [2:0] EV_POP   = 3'd1;
  localparam logic [2:0] EV_ABIT  = 3'd2;
  localparam logic [2:0] EV_DBIT  = 3'd3;
  localparam logic [2:0] EV_DONE  = 3'd4;
  localparam logic [2:0] EV_ERR   = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_txn_sched_if #(.NREQ(NREQ), .LENW(LENW)) bus ();

  i2c_txn_sched #(.NREQ(NREQ), .LENW(LENW), .ACK_TO(ACK_TO), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.grant, bus.tx_pop, bus.done, bus.err, bus.m_start, bus.m_aout,
                bus.m_validaddr, bus.m_dout, bus.m_validdata});
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push(input logic [2:0] k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_bits(input logic [2:0] k, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) push(k, {7'd0, b[i]});
  endtask

  task automatic exp_txn(input int g, input logic [7:0] addr, input int npop,
                         input logic [7:0] d0, input logic [7:0] d1, input bit ok);
    logic [7:0] oh;
    oh    = '0;
    oh[g] = 1'b1;
    push(EV_GRANT, oh);
    push_bits(EV_ABIT, addr, 8);
    if (npop > 0) begin
      push(EV_POP, oh);
      push_bits(EV_DBIT, d0, 8);
    end
    if (npop > 1) begin
      push(EV_POP, oh);
      push_bits(EV_DBIT, d1, 8);
    end
    push(ok ? EV_DONE : EV_ERR, oh);
  endtask

  task automatic sb_observe(input logic [2:0] kind, input logic [7:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d val %0h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("sb_event {kind,val}", {21'd0, kind, val}, {21'd0, e.kind, e.val});
    end
  endtask

  logic [NREQ-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_grant <= '0;
    end else begin
      if (bus.grant != '0 && prev_grant == '0) sb_observe(EV_GRANT, 8'(bus.grant));
      if (bus.tx_pop != '0) sb_observe(EV_POP, 8'(bus.tx_pop));
      if (bus.m_validaddr) sb_observe(EV_ABIT, {7'd0, bus.m_aout});
      if (bus.m_validdata) sb_observe(EV_DBIT, {7'd0, bus.m_dout});
      if (bus.done != '0) sb_observe(EV_DONE, 8'(bus.done));
      if (bus.err != '0) sb_observe(EV_ERR, 8'(bus.err));
      prev_grant <= bus.grant;
    end
  end

  // ---------------- requester + ack responder model ----------------
  logic [7:0] bytes [NREQ][3];
  int         bidx [NREQ];
  int         addr_delay;
  int         data_delay [3];
  int         phase, cnt, dbyte;
  logic       prev_va, prev_vd;

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.tx_pop[i] && bidx[i] < 2) begin
        bidx[i]++;
        bus.tx_byte[i*8 +: 8] = bytes[i][bidx[i]];
      end
      if (bus.grant[i]) bus.req_valid[i] = 1'b0;
    end
    // ack phase = cycles with m_start high and no valid, right after a serial field
    if (prev_va && !bus.m_validaddr && bus.m_start) begin
      phase = 1; cnt = 0; dbyte = -1;
    end else if (prev_vd && !bus.m_validdata && bus.m_start) begin
      phase = 2; cnt = 0; dbyte++;
    end else if (phase != 0 && bus.m_start && !bus.m_validaddr && !bus.m_validdata) begin
      cnt++;
    end else begin
      phase = 0;
    end
    bus.m_slave_ack = (phase == 1 && cnt == addr_delay);
    bus.m_data_ack  = (phase == 2 && dbyte >= 0 && dbyte < 3 && cnt == data_delay[dbyte]);
    prev_va = bus.m_validaddr;
    prev_vd = bus.m_validdata;
  endtask

  task automatic start_req(input int i, input logic [7:0] addr, input int len,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bytes[i][0] = d0;
    bytes[i][1] = d1;
    bytes[i][2] = d2;
    bidx[i] = 0;
    bus.tx_byte[i*8 +: 8]      = d0;
    bus.req_addr[i*8 +: 8]     = addr;
    bus.req_len[i*LENW +: LENW] = LENW'(len);
    bus.req_valid[i]           = 1'b1;
  endtask

  // Waits for ntx done/err pulses; returns cycles until the last one, then idles 2 cycles
  task automatic wait_done(input string name, input int ntx, input int budget, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    while (seen < ntx && cyc < budget) begin
      tick();
      cyc++;
      if ((bus.done | bus.err) != '0) seen++;
    end
    check(name, seen, ntx);
    tick();
    tick();
  endtask

  task automatic wait_sig(input string name, input int which, input logic lvl, input int budget);
    int n;
    logic v;
    n = 0;
    v = (which == 0) ? bus.m_validaddr : bus.m_validdata;
    while (v !== lvl && n < budget) begin
      tick();
      n++;
      v = (which == 0) ? bus.m_validaddr : bus.m_validdata;
    end
    if (v !== lvl) check(name, v, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, z;
    reset = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_len = '0; bus.tx_byte = '0;
    bus.m_slave_ack = 1'b0; bus.m_data_ack = 1'b0;
    addr_delay = 0;
    for (int i = 0; i < 3; i++) data_delay[i] = 0;
    for (int i = 0; i < NREQ; i++) bidx[i] = 0;
    phase = 0; cnt = 0; dbyte = -1; prev_va = 1'b0; prev_vd = 1'b0;
    #2 reset = 1'b1;
    #2 check("reset_outputs", outs(), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();

    // T1: requester 0, addr A4 (1,0,1,0,0,1,0,0), bytes 5A, C3, immediate acks
    start_req(0, 8'hA4, 2, 8'h5A, 8'hC3, 8'h00);
    exp_txn(0, 8'hA4, 2, 8'h5A, 8'hC3, 1'b1);
    tick();
    check("t1_start_after_req", {31'd0, bus.m_start}, 32'd1);
    check("t1_no_addr_in_start", {31'd0, bus.m_validaddr}, 32'd0);
    tick();
    check("t1_first_addr_bit", {31'd0, bus.m_validaddr}, 32'd1);
    n = 2;
    while (bus.done == '0 && n < 100) begin
      tick();
      n++;
    end
    check("t1_latency_to_done", n, 30);
    check("t1_grant_in_last_stop", 32'(bus.grant), 32'h1);
    tick();
    check("t1_grant_idle", 32'(bus.grant), 32'h0);
    tick();

    // T2: requesters 1 and 3 together; 1 first, 3 after exactly one idle cycle
    start_req(1, 8'h30, 1, 8'h81, 8'h00, 8'h00);
    start_req(3, 8'hE1, 1, 8'h7E, 8'h00, 8'h00);
    exp_txn(1, 8'h30, 1, 8'h81, 8'h00, 1'b1);
    exp_txn(3, 8'hE1, 1, 8'h7E, 8'h00, 1'b1);
    n = 0;
    while (bus.grant != 4'b0010 && n < 20) begin tick(); n++; end
    check("t2_first_grant", 32'(bus.grant), 32'h2);
    n = 0;
    while (bus.grant == 4'b0010 && n < 60) begin tick(); n++; end
    z = 0;
    while (bus.grant == '0 && z < 10) begin tick(); z++; end
    check("t2_idle_cycles_between", z, 1);
    check("t2_second_grant", 32'(bus.grant), 32'h8);
    wait_done("t2_done_seen", 1, 60, n);

    // T3: len=0 on requesters 0 and 2; rr_ptr wrapped to 0 so 0 wins
    start_req(0, 8'h42, 0, 8'h00, 8'h00, 8'h00);
    start_req(2, 8'h18, 0, 8'h00, 8'h00, 8'h00);
    exp_txn(0, 8'h42, 0, 8'h00, 8'h00, 1'b1);
    exp_txn(2, 8'h18, 0, 8'h00, 8'h00, 1'b1);
    n = 0;
    while (bus.done == '0 && n < 40) begin tick(); n++; end
    check("t3_len0_latency", n, 12);
    wait_done("t3_done_seen", 1, 40, n);

    // T4: address never acked -> 16 ack cycles, err pulse
    addr_delay = 99;
    start_req(1, 8'h9E, 1, 8'hAA, 8'h00, 8'h00);
    exp_txn(1, 8'h9E, 0, 8'h00, 8'h00, 1'b0);
    wait_sig("t4_addr_start", 0, 1'b1, 20);
    wait_sig("t4_addr_end", 0, 1'b0, 20);
    n = 0;
    while (bus.m_start && n < 100) begin n++; tick(); end
    check("t4_aack_cycles", n, 16);
    wait_done("t4_err_seen", 1, 10, z);
    addr_delay = 0;

    // T5: second data byte acked on the final timeout cycle -> done
    data_delay[0] = 0;
    data_delay[1] = 15;
    start_req(2, 8'h3C, 2, 8'hF0, 8'h0F, 8'h00);
    exp_txn(2, 8'h3C, 2, 8'hF0, 8'h0F, 1'b1);
    wait_done("t5_done_seen", 1, 100, n);
    check("t5_latency", n, 45);
    data_delay[1] = 0;

    // T6: reset during DATA bit 4
    start_req(2, 8'h55, 3, 8'h96, 8'h11, 8'h22);
    push(EV_GRANT, 8'h04);
    push_bits(EV_ABIT, 8'h55, 8);
    push(EV_POP, 8'h04);
    push_bits(EV_DBIT, 8'h96, 4);
    wait_sig("t6_data_start", 1, 1'b1, 30);
    n = 1;
    while (n < 4) begin tick(); n++; end
    check("t6_in_data", {31'd0, bus.m_validdata}, 32'd1);
    #2 reset = 1'b1;
    #1 check("t6_async_reset_outputs", outs(), 32'd0);
    bus.req_valid = '0;
    bus.m_slave_ack = 1'b0;
    bus.m_data_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    phase = 0; prev_va = 1'b0; prev_vd = 1'b0;
    repeat (5) tick();
    check("t6_no_pulse_after_reset", exp_q.size(), 0);
    start_req(0, 8'h11, 0, 8'h00, 8'h00, 8'h00);
    start_req(3, 8'h22, 0, 8'h00, 8'h00, 8'h00);
    exp_txn(0, 8'h11, 0, 8'h00, 8'h00, 1'b1);
    exp_txn(3, 8'h22, 0, 8'h00, 8'h00, 1'b1);
    wait_done("t6_post_reset_done", 2, 80, n);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
